// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, illegal-code check, flag bit positions
// and the request/response bundles used by alu_arbiter.
package alu_pkg;

  localparam int NREQ = 2;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SLL    = 4'b0001;
  localparam logic [3:0] ALU_SLT    = 4'b0010;
  localparam logic [3:0] ALU_SLTU   = 4'b0011;
  localparam logic [3:0] ALU_XOR    = 4'b0100;
  localparam logic [3:0] ALU_SRL    = 4'b0101;
  localparam logic [3:0] ALU_OR     = 4'b0110;
  localparam logic [3:0] ALU_AND    = 4'b0111;
  localparam logic [3:0] ALU_SUB    = 4'b1000;
  localparam logic [3:0] ALU_SLL_A  = 4'b1001;
  localparam logic [3:0] ALU_SLT_A  = 4'b1010;
  localparam logic [3:0] ALU_SLTU_A = 4'b1011;
  localparam logic [3:0] ALU_ILL0   = 4'b1100;
  localparam logic [3:0] ALU_SRA    = 4'b1101;
  localparam logic [3:0] ALU_ILL1   = 4'b1110;
  localparam logic [3:0] ALU_AND_A  = 4'b1111;

  // Flag vector is {lts,gtes,ltu,gteu,eq}
  localparam int FLG_EQ   = 0;
  localparam int FLG_GTEU = 1;
  localparam int FLG_LTU  = 2;
  localparam int FLG_GTES = 3;
  localparam int FLG_LTS  = 4;
  localparam int FLG_W    = 5;

  function automatic logic is_illegal(input logic [3:0] c);
    return (c == ALU_ILL0) || (c == ALU_ILL1);
  endfunction

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic        sub;
  } alu_req_t;

  typedef struct packed {
    logic [31:0]      res;
    logic [FLG_W-1:0] flags;
    logic             err;
  } alu_resp_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU. Comparison flags always relate a to b; eq tracks a zero result.
module alu
  import alu_pkg::*;
(
  input  logic [31:0]      a_i,
  input  logic [31:0]      b_i,
  input  logic [3:0]       ctrl_i,
  input  logic             sub_i,
  output logic [31:0]      res_o,
  output logic [FLG_W-1:0] flags_o,
  output logic             err_o
);

  logic [4:0] shamt;
  logic       lts, ltu;

  assign shamt = b_i[4:0];
  assign lts   = $signed(a_i) < $signed(b_i);
  assign ltu   = a_i < b_i;

  always_comb begin
    res_o = '0;
    err_o = 1'b0;
    unique case (ctrl_i)
      ALU_ADD:              res_o = a_i + b_i;
      ALU_SUB:              res_o = sub_i ? (a_i - b_i) : (a_i + b_i);
      ALU_SLL, ALU_SLL_A:   res_o = a_i << shamt;
      ALU_SLT, ALU_SLT_A:   res_o = {31'b0, lts};
      ALU_SLTU, ALU_SLTU_A: res_o = {31'b0, ltu};
      ALU_XOR:              res_o = a_i ^ b_i;
      ALU_SRL:              res_o = a_i >> shamt;
      ALU_SRA:              res_o = $unsigned($signed(a_i) >>> shamt);
      ALU_OR:               res_o = a_i | b_i;
      ALU_AND, ALU_AND_A:   res_o = a_i & b_i;
      default:              err_o = is_illegal(ctrl_i);
    endcase
  end

  always_comb begin
    flags_o           = '0;
    flags_o[FLG_LTS]  = lts;
    flags_o[FLG_GTES] = ~lts;
    flags_o[FLG_LTU]  = ltu;
    flags_o[FLG_GTEU] = ~ltu;
    flags_o[FLG_EQ]   = (res_o == 32'h0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port round-robin front end sharing one alu, with a single registered response slot.
// Define ALU_ARB_FIXED_PRIO_EN to make port 0 win every tie.
module alu_arbiter
  import alu_pkg::*;
(
  input  logic                       clk_w_i,
  input  logic                       rst_w_i_h,
  input  logic [NREQ-1:0]            req_valid_w_i,
  output logic [NREQ-1:0]            req_ready_w_o,
  input  logic [NREQ-1:0][31:0]      req_a_w_i,
  input  logic [NREQ-1:0][31:0]      req_b_w_i,
  input  logic [NREQ-1:0][3:0]       req_ctrl_w_i,
  input  logic [NREQ-1:0]            req_sub_w_i,
  output logic [NREQ-1:0]            resp_valid_w_o,
  input  logic [NREQ-1:0]            resp_ready_w_i,
  output logic [31:0]                resp_res_w_o,
  output logic [FLG_W-1:0]           resp_flags_w_o,
  output logic                       resp_err_w_o
);

  logic [NREQ-1:0] resp_valid_q, resp_valid_d;
  alu_resp_t       slot_q, slot_d;
  logic            last_gnt_q, last_gnt_d;

  logic [NREQ-1:0] gnt;
  logic            slot_free, drain, accept, sel;
  alu_req_t        alu_req;
  alu_resp_t       alu_out;

  // Owner consuming this cycle frees the slot for a same-cycle refill
  assign drain     = |(resp_valid_q & resp_ready_w_i);
  assign slot_free = ~(|resp_valid_q) | drain;

  always_comb begin
    gnt = req_valid_w_i;
    if (&req_valid_w_i) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      gnt = 2'b01;
`else
      gnt = last_gnt_q ? 2'b01 : 2'b10;
`endif
    end
  end

  assign req_ready_w_o = rst_w_i_h ? '0 : (gnt & {NREQ{slot_free}});
  assign accept        = |(req_valid_w_i & req_ready_w_o);
  assign sel           = req_ready_w_o[1];

  assign alu_req.a    = req_a_w_i[sel];
  assign alu_req.b    = req_b_w_i[sel];
  assign alu_req.ctrl = req_ctrl_w_i[sel];
  assign alu_req.sub  = req_sub_w_i[sel];

  alu u_alu (
    .a_i    (alu_req.a),
    .b_i    (alu_req.b),
    .ctrl_i (alu_req.ctrl),
    .sub_i  (alu_req.sub),
    .res_o  (alu_out.res),
    .flags_o(alu_out.flags),
    .err_o  (alu_out.err)
  );

  always_comb begin
    resp_valid_d = resp_valid_q;
    slot_d       = slot_q;
    last_gnt_d   = last_gnt_q;
    if (accept) begin
      resp_valid_d = req_ready_w_o;
      slot_d       = alu_out;
      last_gnt_d   = sel;
    end else if (drain) begin
      resp_valid_d = '0;
    end
  end

  always_ff @(posedge clk_w_i) begin
    if (rst_w_i_h) begin
      resp_valid_q <= '0;
      slot_q       <= '0;
      last_gnt_q   <= 1'b1;
    end else begin
      resp_valid_q <= resp_valid_d;
      slot_q       <= slot_d;
      last_gnt_q   <= last_gnt_d;
    end
  end

  assign resp_valid_w_o = resp_valid_q;
  assign resp_res_w_o   = slot_q.res;
  assign resp_flags_w_o = slot_q.flags;
  assign resp_err_w_o   = slot_q.err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus a randomized run against a behavioural model.
module tb_alu_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_a, req_b;
  logic [1:0][3:0]  req_ctrl;
  logic [1:0]       req_sub;
  logic [1:0]       resp_valid;
  logic [1:0]       resp_ready;
  logic [31:0]      resp_res;
  logic [4:0]       resp_flags;
  logic             resp_err;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: held response and which port won last
  logic [1:0]  m_valid;
  logic [31:0] m_res;
  logic [4:0]  m_flags;
  logic        m_err;
  int          m_last;

  alu_arbiter dut (
    .clk_w_i       (clk),
    .rst_w_i_h     (rst),
    .req_valid_w_i (req_valid),
    .req_ready_w_o (req_ready),
    .req_a_w_i     (req_a),
    .req_b_w_i     (req_b),
    .req_ctrl_w_i  (req_ctrl),
    .req_sub_w_i   (req_sub),
    .resp_valid_w_o(resp_valid),
    .resp_ready_w_i(resp_ready),
    .resp_res_w_o  (resp_res),
    .resp_flags_w_o(resp_flags),
    .resp_err_w_o  (resp_err)
  );

  always #5 clk = ~clk;

  // Returns {err, lts, gtes, ltu, gteu, eq, res}
  function automatic logic [37:0] ref_alu(input logic [3:0] c, input logic s,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic e, lts, ltu;
    int sh;
    sh = int'(b % 32);
    lts = $signed(a) < $signed(b);
    ltu = a < b;
    r = 0;
    e = 0;
    case (c)
      4'd0:        r = a + b;
      4'd8:        r = s ? a - b : a + b;
      4'd1, 4'd9:  r = a << sh;
      4'd2, 4'd10: r = lts ? 1 : 0;
      4'd3, 4'd11: r = ltu ? 1 : 0;
      4'd4:        r = a ^ b;
      4'd5:        r = a >> sh;
      4'd13:       r = $unsigned($signed(a) >>> sh);
      4'd6:        r = a | b;
      4'd7, 4'd15: r = a & b;
      default:     e = 1;
    endcase
    return {e, lts, !lts, ltu, !ltu, r == 0, r};
  endfunction

  task automatic model_ready(output logic [1:0] rdy);
    bit free;
    int w;
    rdy = 0;
    free = (m_valid == 0) || ((m_valid & resp_ready) != 0);
    w = -1;
    if (req_valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      w = 0;
`else
      w = (m_last == 0) ? 1 : 0;
`endif
    end else if (req_valid[0]) w = 0;
    else if (req_valid[1]) w = 1;
    if (!rst && free && w >= 0) rdy = (w == 0) ? 2'b01 : 2'b10;
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge
  task automatic tick();
    logic [1:0] r;
    logic [37:0] o;
    int w;
    model_ready(r);
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_res = 0; m_flags = 0; m_err = 0; m_last = 1;
    end else if (r != 0) begin
      w = r[1] ? 1 : 0;
      o = ref_alu(req_ctrl[w], req_sub[w], req_a[w], req_b[w]);
      m_res = o[31:0]; m_flags = o[36:32]; m_err = o[37];
      m_valid = r; m_last = w;
    end else if ((m_valid & resp_ready) != 0) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic set_port(input int p, input logic v, input logic [3:0] c, input logic s,
                          input logic [31:0] a, input logic [31:0] b);
    req_valid[p] = v; req_ctrl[p] = c; req_sub[p] = s; req_a[p] = a; req_b[p] = b;
  endtask

  task automatic idle_drain();
    req_valid = 0; resp_ready = 2'b11;
    tick();
  endtask

  task automatic do_reset();
    rst = 1; req_valid = 0; resp_ready = 0;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; req_valid = 2'b11; resp_ready = 2'b11;
    req_a = 0; req_b = 0; req_ctrl = 0; req_sub = 0;
    #1;
    n_cmp++;
    if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_ready got %b want 00", req_ready); end
    tick();
    n_cmp++;
    if (resp_valid !== 2'b00) begin n_err++; $display("FAIL reset_valid got %b want 00", resp_valid); end
    n_cmp++;
    if (resp_res !== 32'h0 || resp_flags !== 5'h0 || resp_err !== 1'b0) begin
      n_err++; $display("FAIL reset_data got %h/%b/%b want 0/0/0", resp_res, resp_flags, resp_err);
    end
    rst = 0; req_valid = 0;
  endtask

  task automatic test_basic();
    do_reset();
    set_port(0, 1, 4'b0000, 0, 32'd5, 32'd7);
    #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin n_err++; $display("FAIL basic_ready got %b want 01", req_ready); end
    tick();
    req_valid = 0;
    n_cmp++;
    if (resp_valid !== 2'b01 || resp_res !== 32'd12 || resp_flags[0] !== 1'b0) begin
      n_err++; $display("FAIL basic_resp got v=%b r=%0d eq=%b want v=01 r=12 eq=0", resp_valid, resp_res, resp_flags[0]);
    end
    idle_drain();
    n_cmp++;
    if (resp_valid !== 2'b00) begin n_err++; $display("FAIL basic_drain got %b want 00", resp_valid); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] want;
    do_reset();
    resp_ready = 2'b11;
    for (int i = 0; i < 4; i++) begin
      for (int p = 0; p < 2; p++)
        set_port(p, 1, 4'($urandom_range(0, 11)), 1'($urandom), $urandom, $urandom);
`ifdef ALU_ARB_FIXED_PRIO_EN
      want = 2'b01;
`else
      want = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
      #1;
      n_cmp++;
      if (req_ready !== want) begin n_err++; $display("FAIL b2b_ready[%0d] got %b want %b", i, req_ready, want); end
      tick();
      n_cmp++;
      if (resp_valid !== want || resp_res !== m_res || resp_flags !== m_flags || resp_err !== m_err) begin
        n_err++; $display("FAIL b2b_resp[%0d] got v=%b r=%h f=%b want v=%b r=%h f=%b",
                          i, resp_valid, resp_res, resp_flags, want, m_res, m_flags);
      end
    end
    idle_drain();
  endtask

  task automatic test_hold();
    do_reset();
    set_port(1, 1, 4'b1000, 1, 32'd3, 32'd3);
    resp_ready = 2'b00;
    tick();
    req_valid[1] = 0;
    set_port(0, 1, 4'b0000, 0, 32'd100, 32'd23);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (req_ready !== 2'b00) begin n_err++; $display("FAIL hold_ready[%0d] got %b want 00", i, req_ready); end
      n_cmp++;
      if (resp_valid !== 2'b10 || resp_res !== 32'h0 || resp_flags !== 5'b01011) begin
        n_err++; $display("FAIL hold_data[%0d] got v=%b r=%h f=%b want v=10 r=0 f=01011", i, resp_valid, resp_res, resp_flags);
      end
      resp_ready[0] = 1'b1;  // non-owner consume must be ignored
      tick();
      resp_ready[0] = 1'b0;
    end
    resp_ready = 2'b10;
    #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin n_err++; $display("FAIL hold_refill_ready got %b want 01", req_ready); end
    tick();
    n_cmp++;
    if (resp_valid !== 2'b01 || resp_res !== 32'd123) begin
      n_err++; $display("FAIL hold_refill got v=%b r=%0d want v=01 r=123", resp_valid, resp_res);
    end
    idle_drain();
  endtask

  task automatic test_err();
    do_reset();
    set_port(0, 1, 4'b1100, 0, 32'h1234_5678, 32'h9abc_def0);
    tick();
    req_valid = 0;
    n_cmp++;
    if (resp_valid !== 2'b01 || resp_err !== 1'b1 || resp_res !== 32'h0) begin
      n_err++; $display("FAIL err_resp got v=%b e=%b r=%h want v=01 e=1 r=0", resp_valid, resp_err, resp_res);
    end
    idle_drain();
  endtask

  task automatic test_sra();
    set_port(0, 1, 4'b1101, 0, 32'h8000_0000, 32'h21);
    tick();
    req_valid = 0;
    n_cmp++;
    if (resp_res !== 32'hC000_0000 || resp_flags[4] !== 1'b1 || resp_flags[2] !== 1'b0 || resp_err !== 1'b0) begin
      n_err++; $display("FAIL sra got r=%h lts=%b ltu=%b e=%b want r=c0000000 lts=1 ltu=0 e=0",
                        resp_res, resp_flags[4], resp_flags[2], resp_err);
    end
    idle_drain();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_port(1, 1, 4'b0000, 0, 32'd1, 32'd1);
    tick();
    set_port(0, 1, 4'b0110, 0, 32'hf0, 32'h0f);
    resp_ready = 2'b10;
    tick();
    n_cmp++;
    if (resp_valid !== 2'b01) begin n_err++; $display("FAIL rstmid_setup got %b want 01", resp_valid); end
    rst = 1; req_valid = 2'b11; resp_ready = 2'b00;
    #1;
    n_cmp++;
    if (req_ready !== 2'b00) begin n_err++; $display("FAIL rstmid_ready got %b want 00", req_ready); end
    tick();
    rst = 0;
    n_cmp++;
    if (resp_valid !== 2'b00 || resp_res !== 32'h0 || resp_flags !== 5'h0 || resp_err !== 1'b0) begin
      n_err++; $display("FAIL rstmid_clear got v=%b r=%h f=%b e=%b want all 0", resp_valid, resp_res, resp_flags, resp_err);
    end
    #1;
    n_cmp++;
    if (req_ready !== 2'b01) begin n_err++; $display("FAIL rstmid_tie got %b want 01", req_ready); end
    idle_drain();
  endtask

  task automatic test_random();
    logic [1:0] want;
    logic [31:0] a;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!req_valid[p] && ($urandom % 3 != 0)) begin
          a = $urandom;
          set_port(p, 1, 4'($urandom_range(0, 15)), 1'($urandom), a,
                   ($urandom % 4 == 0) ? a : $urandom);
        end
      end
      resp_ready = ($urandom % 4 == 0) ? 2'($urandom) : 2'b11;
      #1;
      model_ready(want);
      n_cmp++;
      if (req_ready !== want) begin n_err++; $display("FAIL rand_ready[%0d] got %b want %b", i, req_ready, want); end
      tick();
      n_cmp++;
      if (resp_valid !== m_valid || resp_res !== m_res || resp_flags !== m_flags || resp_err !== m_err) begin
        n_err++; $display("FAIL rand_resp[%0d] got v=%b r=%h f=%b e=%b want v=%b r=%h f=%b e=%b",
                          i, resp_valid, resp_res, resp_flags, resp_err, m_valid, m_res, m_flags, m_err);
      end
      req_valid = req_valid & ~want;
    end
    idle_drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_hold();
    test_err();
    test_sra();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter that shares one `alu` instance between the execute stage (port 0) and a secondary requester (port 1, e.g. the debug/CSR unit). It accepts operations through valid/ready handshakes and arbitrates round-robin. It registers the ALU result and comparison flags into a single output slot, and returns them to the winning requester through a one-hot response handshake.

## Interface
Parameters:
- `NREQ`, 2: number of requesters. Fixed at 2; the value is recorded for the package.

Ports:
- `clk_w_i`  in  1  clock; all state updates on the rising edge
- `rst_w_i_h`  in  1  synchronous, active-high reset
- `req_valid_w_i`  in  2  per-port request valid
- `req_ready_w_o`  out  2  per-port request accepted this cycle
- `req_a_w_i`  in  2x32  operand A per port, packed `{p1,p0}`
- `req_b_w_i`  in  2x32  operand B per port, packed
- `req_ctrl_w_i`  in  2x4  ALU control code per port
- `req_sub_w_i`  in  2  addi/sub flag per port
- `resp_valid_w_o`  out  2  one-hot; the bit set marks the owner of the held result
- `resp_ready_w_i`  in  2  per-port response consume
- `resp_res_w_o`  out  32  registered ALU result
- `resp_flags_w_o`  out  5  registered `{lts,gtes,ltu,gteu,eq}`
- `resp_err_w_o`  out  1  registered; control code was 4'b1100 or 4'b1110

## Operation
- **Output slot.** One output slot, with `slot_full` equal to the OR of `resp_valid_w_o`.
  - Slot is free when `!slot_full`, or when the owner's `resp_ready_w_i` bit is high this cycle (drain and refill in the same cycle).
- **Arbitration.** Combinational, each cycle:
  - Only port i valid: grant i.
  - Both ports valid: grant the port opposite `last_gnt`.
  - `req_ready_w_o[i]` = grant[i] AND slot free.
  - At most one ready bit is high. Ready never asserts for a port whose valid is low.
- **Accept.** On accept (`req_valid & req_ready`) for port i:
  - The muxed operands of port i drive the `alu`.
  - Its outputs are captured into `resp_res_w_o`/`resp_flags_w_o`.
  - `resp_err_w_o` is set if the code is 4'b1100 or 4'b1110. In that case `resp_res_w_o` is 32'h0, not X.
  - `resp_valid_w_o` becomes one-hot i.
  - `last_gnt` is set to i.
- **Drain.** With no accept, `resp_ready_w_i[owner]` clears `resp_valid_w_o`. Data registers hold their values.
  - `resp_ready_w_i` bits for non-owners are ignored.
- **Hold.** Held response data is stable while `resp_valid_w_o` is non-zero and not consumed.
- **Arithmetic.** Per `alu`: 32-bit wrap-around add/sub, shift amount = `b[4:0]`, and `eq` reflects result == 0.
  - Example: SUB of equal operands gives `eq`=1.
- **Reset mid-operation.** A pending response is discarded. No ready is asserted in the reset cycle.

## Timing
- Reset values:
  - `resp_valid_w_o`=2'b00
  - `resp_res_w_o`=0
  - `resp_flags_w_o`=0
  - `resp_err_w_o`=0
  - `last_gnt`=1, so port 0 wins the first tie
  - `req_ready_w_o`=0 while `rst_w_i_h` is high
- Latency: accept in cycle N gives a response visible in cycle N+1.
- Throughput: 1 op/cycle when the owner holds `resp_ready_w_i` high continuously.
- `req_ready_w_o` is combinational from `req_valid_w_i`, `resp_valid_w_o`, `resp_ready_w_i` and `last_gnt`. Requesters must not make valid depend on ready.
- Requester rule: once `req_valid_w_i[i]` is raised, it and the payload stay stable until accepted.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN`:
  - Defined: port 0 always wins ties. `last_gnt` is still tracked but not used for arbitration. Port 1 can starve.
  - Undefined (default): round-robin as described above.

## Structure
- Shared package `alu_pkg` holds:
  - the ALU control code constants (ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND, SUB/ADDI 4'b1000, SRA 4'b1101, and the aliases 4'b1001/1010/1011/1111)
  - the illegal-code list
  - the flag-vector bit positions
  - `NREQ`
- One sub-module: the existing `alu`, instantiated once. The grant mux and output slot stay inline.

## Test plan
- After reset, port 0 ADD a=5, b=7 → `req_ready_w_o`=01 same cycle; next cycle `resp_valid_w_o`=01, `resp_res_w_o`=12, eq=0.
- Both ports valid for 4 cycles, `resp_ready_w_i`=11: grants alternate 0,1,0,1; responses are one-hot in that order, back-to-back, with no bubble.
- Port 1 SUB a=3, b=3, sub=1 with `resp_ready_w_i`=00 for 3 cycles:
  - the result holds 0 with eq=1 and `resp_valid_w_o`=10;
  - a new port-0 request sees ready=0 until port 1 consumes, then is accepted the same cycle.
- Port 0 ctrl=4'b1100 → `resp_err_w_o`=1, `resp_res_w_o`=0.
- Port 0 SRA a=32'h8000_0000, b=32'h21 (shift = 1):
  - result = 32'hC000_0000;
  - lts=1 and ltu=0 are captured unchanged.
- `rst_w_i_h` pulsed while `resp_valid_w_o`=01 → next cycle all outputs are 0; the next tie goes to port 0. With `ALU_ARB_FIXED_PRIO_EN` defined, a continuous tie always grants port 0.
